memwr_capture: RTL
==================

# memwr_capture

Write-side observer for the accumulator CPU's external memory bus (MemRW_IO / MemAddr_IO / MemD_IO). It detects each CPU store and records its (address, data) pair in an internal first-word-fall-through FIFO. The FIFO drains through a valid/ready port to a checker or host. Overflows are flagged and counted, never silently lost.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..64.
- AW, 8: address width; matches MemAddr_IO.
- DW, 16: data width; matches MemD_IO.
- clk, input, 1: clock. All state changes on the rising edge.
- rst, input, 1: reset, synchronous, active-high. Clock is clk.
- clear, input, 1: synchronous flush of FIFO, overflow and drop_cnt.
- MemRW, input, 1: CPU write strobe; 1 means write.
- MemAddr, input, AW: CPU address.
- MemD, input, DW: CPU write data.
- out_valid, output, 1: head entry available.
- out_ready, input, 1: consumer accepts head.
- out_addr, output, AW: head address; 0 when out_valid=0.
- out_data, output, DW: head data; 0 when out_valid=0.
- count, output, log2(DEPTH)+1: entries held, 0..DEPTH.
- full, output, 1: count==DEPTH.
- overflow, output, 1: sticky; at least one store dropped.
- drop_cnt, output, 8: dropped stores, saturates at 255.

## Operation
- Edge-detect FSM, two states:
  - ARMED: MemRW=1 moves to BUSY and generates a push of {MemAddr, MemD} sampled in that same cycle.
  - BUSY: MemRW=0 moves to ARMED. No push while MemRW stays high, even if address or data changes.
- Reset enters BUSY. A store already asserted when reset releases is not captured; MemRW must be seen low first.
- pop = out_valid & out_ready. push comes only from the ARMED to BUSY transition.
- Push with count<DEPTH: entry written at the write pointer; wptr += 1 mod DEPTH.
- Pop: rptr += 1 mod DEPTH.
- Both pointers wrap silently. count tracks occupancy and distinguishes full from empty.
- Simultaneous push and pop:
  - Both are performed and count is unchanged.
  - This holds when full: the entry freed by the pop accepts the push, there is no drop, and full stays 1.
  - This holds when empty: the push is written and the pop is ignored because out_valid=0; count becomes 1.
- Push while full with no pop:
  - The store is dropped and FIFO contents are unchanged.
  - overflow is set to 1.
  - drop_cnt increments, saturating at 255.
- clear=1:
  - Next state is count=0, pointers=0, overflow=0, drop_cnt=0.
  - Any push or pop in that cycle is discarded.
  - The FSM still updates from MemRW, so a store beginning in the clear cycle is not captured.
- rst has the same effect as clear, plus FSM forced to BUSY. rst has priority over clear.
- out_addr and out_data are combinational from the head entry, masked to 0 when empty.

## Timing
- Reset values: out_valid=0, out_addr=0, out_data=0, count=0, full=0, overflow=0, drop_cnt=0, FSM=BUSY.
- Capture latency: a store first seen high in cycle N shows out_valid=1 and the entry at head in cycle N+1, provided the FIFO was empty.
- count, full, overflow and drop_cnt are registered. They reflect a cycle-N event from cycle N+1.
- Pop handshake:
  - Consumer may hold out_ready high continuously.
  - A head shown with out_valid=1 stays stable until popped, clear or rst.
  - Back-to-back pops are sustained at one entry per cycle.
- Maximum capture rate is one store per two cycles, because MemRW must go low between stores.
- Reset mid-stream: in-flight entries are discarded. A store held high through reset is ignored.

## Test plan
- Reset, then three stores with MemRW high 1, 3 and 2 cycles, pairs (0x10,0x1234), (0x11,0xBEEF), (0x12,0x0001), out_ready=0 -> count=3, exactly 3 entries. Raising out_ready then pops them in order on 3 consecutive cycles, and out_addr/out_data read 0 afterward.
- Latency: single store of (0x20,0xA5A5) in cycle N into empty FIFO -> out_valid=0 in N, out_valid=1 with that pair in N+1.
- Overflow, DEPTH=8, out_ready=0: 11 stores -> full=1, overflow=1, drop_cnt=3, and the FIFO holds the first 8 pairs. Then assert clear for 1 cycle -> count=0, overflow=0, drop_cnt=0.
- Full with simultaneous event: FIFO full, store edge in the same cycle as a pop -> count stays 8, drop_cnt unchanged, and the new pair appears after 7 more pops.
- Wrap-around: 20 stores interleaved with pops, occupancy 0..3 -> the 20 outputs match input order with no loss; count returns to 0.
- Reset with MemRW held high: assert rst while MemRW=1 and keep MemRW high 4 cycles after release -> no capture. Then MemRW low 1 cycle, high 1 cycle with (0x7F,0x00FF) -> exactly one entry, that pair.

Source files
------------

// File: rtl/memwr_capture.sv
// Write-side observer for the accumulator CPU memory bus. Each store edge on MemRW
// records an {address, data} pair in a FWFT FIFO drained through a valid/ready port.
module memwr_capture #(
    parameter int DEPTH = 8,
    parameter int AW    = 8,
    parameter int DW    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   MemRW,
    input  logic [AW-1:0]          MemAddr,
    input  logic [DW-1:0]          MemD,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AW-1:0]          out_addr,
    output logic [DW-1:0]          out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow,
    output logic [7:0]             drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [0:0] ARMED = 1'b0;
    localparam logic [0:0] BUSY  = 1'b1;

    logic [0:0]        state_r;
    logic [0:0]        state_next_s;
    logic [PW-1:0]     wptr_r;
    logic [PW-1:0]     rptr_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_next_s;
    logic              full_r;
    logic              overflow_r;
    logic [7:0]        drop_r;
    logic [AW+DW-1:0]  mem_r [DEPTH];
    logic [AW+DW-1:0]  head_s;

    logic              push_s;
    logic              pop_s;
    logic              is_full_s;
    logic              wr_en_s;
    logic              drop_s;

    // Store edge detection: any high MemRW lands in BUSY, any low MemRW re-arms.
    always_comb begin
        state_next_s = BUSY;
        case (state_r)
            ARMED:   state_next_s = MemRW ? BUSY : ARMED;
            BUSY:    state_next_s = MemRW ? BUSY : ARMED;
            default: state_next_s = BUSY;
        endcase
    end

    // Push/pop qualification; a pop on a full FIFO frees the slot the push needs.
    always_comb begin
        push_s       = (state_r == ARMED) && MemRW;
        pop_s        = (count_r != {CW{1'b0}}) && out_ready;
        is_full_s    = (count_r == DEPTH_C);
        wr_en_s      = push_s && (!is_full_s || pop_s);
        drop_s       = push_s && is_full_s && !pop_s;
        count_next_s = count_r;
        if (wr_en_s && !pop_s) begin
            count_next_s = count_r + CW'(1);
        end else if (!wr_en_s && pop_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Control state: FSM, pointers, occupancy and overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= BUSY;
            wptr_r     <= {PW{1'b0}};
            rptr_r     <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
            drop_r     <= 8'd0;
        end else begin
            state_r <= state_next_s;
            if (clear) begin
                wptr_r     <= {PW{1'b0}};
                rptr_r     <= {PW{1'b0}};
                count_r    <= {CW{1'b0}};
                full_r     <= 1'b0;
                overflow_r <= 1'b0;
                drop_r     <= 8'd0;
            end else begin
                if (wr_en_s) begin
                    wptr_r <= wptr_r + PW'(1);
                end
                if (pop_s) begin
                    rptr_r <= rptr_r + PW'(1);
                end
                count_r <= count_next_s;
                full_r  <= (count_next_s == DEPTH_C);
                if (drop_s) begin
                    overflow_r <= 1'b1;
                    if (drop_r != 8'hFF) begin
                        drop_r <= drop_r + 8'd1;
                    end
                end
            end
        end
    end

    // Entry storage; when full with a pop, the write reuses the slot being read out.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst && !clear) begin
            mem_r[wptr_r] <= {MemAddr, MemD};
        end
    end

    assign head_s    = mem_r[rptr_r];
    assign out_valid = (count_r != {CW{1'b0}});
    assign out_addr  = out_valid ? head_s[AW+DW-1:DW] : {AW{1'b0}};
    assign out_data  = out_valid ? head_s[DW-1:0]     : {DW{1'b0}};
    assign count     = count_r;
    assign full      = full_r;
    assign overflow  = overflow_r;
    assign drop_cnt  = drop_r;

endmodule
